// File: rtl/sampgen.sv
// Sampling-clock / conversion-window frame generator: per frame, W cycles of
// clk_samp, a one-cycle guard, L cycles of conv_active, then a one-cycle conv_done.
module sampgen #(
    parameter int CNT_W  = 8,
    parameter int FCNT_W = 16
) (
`ifdef USE_POWER_PINS
    inout  wire               vdd_d,
    inout  wire               vss_d,
`endif
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [CNT_W-1:0]  samp_width,
    input  logic [CNT_W-1:0]  conv_len,
    output logic              clk_samp,
    output logic              conv_active,
    output logic              conv_done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        HOLD,
        CONVERT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_w;
    logic [CNT_W-1:0]   lat_l;
    logic [CNT_W-1:0]   w_eff;
    logic [CNT_W-1:0]   l_eff;
    logic               entering_sample;

    // A programmed length of zero still gives each phase one cycle.
    assign w_eff = (lat_w == '0) ? CNT_W'(1) : lat_w;
    assign l_eff = (lat_l == '0) ? CNT_W'(1) : lat_l;

    assign entering_sample = (state_next == SAMPLE) && (state != SAMPLE);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start || cont) state_next = SAMPLE;
            SAMPLE:  if (cnt >= w_eff)  state_next = HOLD;
            HOLD:    state_next = CONVERT;
            CONVERT: if (cnt >= l_eff)  state_next = DONE;
            DONE:    state_next = cont ? SAMPLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so each one comes
    // straight off a flop and changes on the same edge as the state.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_w       <= '0;
            lat_l       <= '0;
            clk_samp    <= 1'b0;
            conv_active <= 1'b0;
            conv_done   <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_next;
            clk_samp    <= (state_next == SAMPLE);
            conv_active <= (state_next == CONVERT);
            conv_done   <= (state_next == DONE);
            busy        <= (state_next != IDLE);

            if (entering_sample) begin
                lat_w <= samp_width;
                lat_l <= conv_len;
            end

            // Phase counter restarts at 1 on each state change and counts the
            // cycles already spent in SAMPLE or CONVERT.
            if (state_next != state) begin
                cnt <= CNT_W'(1);
            end else if (state == SAMPLE || state == CONVERT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state_next == DONE && state != DONE) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sampgen.sv
// Directed bench for sampgen: per-cycle output traces against hand-computed
// bit patterns, continuous mode, ignored start, abort and counter wrap.
module tb_sampgen;

    localparam int CNT_W  = 8;
    localparam int FCNT_W = 4;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic [CNT_W-1:0]  samp_width = '0;
    logic [CNT_W-1:0]  conv_len = '0;
    logic              clk_samp;
    logic              conv_active;
    logic              conv_done;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    int n_checks = 0;
    int n_bad = 0;
    int overlap_cycles = 0;

    sampgen #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .samp_width  (samp_width),
        .conv_len    (conv_len),
        .clk_samp    (clk_samp),
        .conv_active (conv_active),
        .conv_done   (conv_done),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (clk_samp && conv_active) overlap_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Record n consecutive cycles of outputs, bit i = cycle i from now.
    task automatic capture(input int n, output logic [63:0] cs, output logic [63:0] ca,
                           output logic [63:0] cd, output logic [63:0] bz);
        cs = '0; ca = '0; cd = '0; bz = '0;
        for (int i = 0; i < n; i++) begin
            cs[i] = clk_samp;
            ca[i] = conv_active;
            cd[i] = conv_done;
            bz[i] = busy;
            step();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [63:0] cs, ca, cd, bz;
    int          dones;
    logic [FCNT_W-1:0] cnt_at_done [16];

    initial begin
        // Reset state
        step();
        step();
        check("rst_clk_samp", 64'(clk_samp), 64'd0);
        check("rst_conv_active", 64'(conv_active), 64'd0);
        check("rst_conv_done", 64'(conv_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        step();
        step();
        check("idle_after_rst", 64'(busy), 64'd0);

        // Single frame W=3 L=5
        samp_width = 8'd3;
        conv_len = 8'd5;
        pulse_start();
        capture(14, cs, ca, cd, bz);
        check("single_clk_samp", cs, 64'h7);
        check("single_conv_active", ca, 64'h1F0);
        check("single_conv_done", cd, 64'h200);
        check("single_busy", bz, 64'h3FF);
        check("single_frame_cnt", 64'(frame_cnt), 64'd1);

        // Zero configuration behaves as 1/1
        samp_width = 8'd0;
        conv_len = 8'd0;
        pulse_start();
        capture(8, cs, ca, cd, bz);
        check("zero_clk_samp", cs, 64'h1);
        check("zero_conv_active", ca, 64'h4);
        check("zero_conv_done", cd, 64'h8);
        check("zero_busy", bz, 64'hF);
        check("zero_frame_cnt", 64'(frame_cnt), 64'd2);

        // Continuous W=2 L=2, cont dropped during the 3rd frame's CONVERT
        samp_width = 8'd2;
        conv_len = 8'd2;
        cont = 1'b1;
        step();
        capture(15, cs, ca, cd, bz);
        check("cont_clk_samp", cs, 64'h30C3);
        check("cont_conv_active", ca, 64'h618);
        check("cont_conv_done", cd, 64'h820);
        check("cont_busy", bz, 64'h7FFF);
        cont = 1'b0;
        capture(6, cs, ca, cd, bz);
        check("cont_tail_clk_samp", cs, 64'h0);
        check("cont_tail_conv_active", ca, 64'h3);
        check("cont_tail_conv_done", cd, 64'h4);
        check("cont_tail_busy", bz, 64'h7);
        check("cont_frame_cnt", 64'(frame_cnt), 64'd5);

        // start and samp_width change during CONVERT are ignored for this frame
        samp_width = 8'd3;
        conv_len = 8'd5;
        pulse_start();
        capture(6, cs, ca, cd, bz);
        start = 1'b1;
        samp_width = 8'd7;
        step();
        start = 1'b0;
        capture(8, cs, ca, cd, bz);
        check("ign_clk_samp", cs, 64'h0);
        check("ign_conv_active", ca, 64'h3);
        check("ign_conv_done", cd, 64'h4);
        check("ign_busy", bz, 64'h7);
        check("ign_frame_cnt", 64'(frame_cnt), 64'd6);
        pulse_start();
        capture(16, cs, ca, cd, bz);
        check("w7_clk_samp", cs, 64'h7F);
        check("w7_conv_active", ca, 64'h1F00);
        check("w7_conv_done", cd, 64'h2000);
        check("w7_busy", bz, 64'h3FFF);
        check("w7_frame_cnt", 64'(frame_cnt), 64'd7);

        // Abort on the 2nd CONVERT cycle
        samp_width = 8'd3;
        conv_len = 8'd5;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        check("abort_in_convert", 64'(conv_active), 64'd1);
        rst = 1'b1;
        step();
        check("abort_clk_samp", 64'(clk_samp), 64'd0);
        check("abort_conv_active", 64'(conv_active), 64'd0);
        check("abort_conv_done", 64'(conv_done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_frame_cnt", 64'(frame_cnt), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_over_start", 64'(busy), 64'd0);
        rst = 1'b0;
        capture(8, cs, ca, cd, bz);
        check("abort_no_done", cd, 64'h0);
        check("abort_stays_idle", bz, 64'h0);

        // Wrap: 16 back-to-back 4-cycle frames on a 4-bit counter
        samp_width = 8'd0;
        conv_len = 8'd0;
        cont = 1'b1;
        step();
        dones = 0;
        for (int i = 0; i < 68; i++) begin
            if (i == 60) cont = 1'b0;
            if (conv_done) begin
                if (dones < 16) cnt_at_done[dones] = frame_cnt;
                dones++;
            end
            step();
        end
        check("wrap_done_count", 64'(dones), 64'd16);
        check("wrap_cnt_at_15", 64'(cnt_at_done[14]), 64'd15);
        check("wrap_cnt_at_16", 64'(cnt_at_done[15]), 64'd0);
        check("wrap_final_cnt", 64'(frame_cnt), 64'd0);
        check("wrap_idle", 64'(busy), 64'd0);

        check("no_overlap", 64'(overlap_cycles), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
